// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-ported register file.
package regfile_pkg;

    localparam int XLEN_DEF     = 64;
    localparam int NUM_REGS_DEF = 32;
    localparam int AW_DEF       = $clog2(NUM_REGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per architectural register.
// Next-state priority is reset > allocate > flush > writeback > hold.
// REGFILE_BYPASS_EN: a same-cycle writeback clears the reported busy flag
// unless the same cycle also re-allocates that register.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 6,
    parameter int NUM_WR   = 2,
    parameter int AW       = $clog2(NUM_REGS)
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RD*AW-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]    rd_busy_o,
    input  logic [NUM_WR-1:0]    wr_valid_i,
    input  logic [NUM_WR*AW-1:0] wr_addr_i,
    input  logic [NUM_WR-1:0]    alloc_valid_i,
    input  logic [NUM_WR*AW-1:0] alloc_addr_i,
    input  logic                 flush_i
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Per-register next state; register 0 can never become busy.
    always_comb begin
        logic a_hit;
        logic w_hit;
        busy_d = '0;
        a_hit  = 1'b0;
        w_hit  = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            a_hit = 1'b0;
            w_hit = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (alloc_valid_i[j] && alloc_addr_i[j*AW +: AW] == AW'(r)) a_hit = 1'b1;
                if (wr_valid_i[j]    && wr_addr_i[j*AW +: AW]    == AW'(r)) w_hit = 1'b1;
            end
            if (a_hit)        busy_d[r] = 1'b1;
            else if (flush_i) busy_d[r] = 1'b0;
            else if (w_hit)   busy_d[r] = 1'b0;
            else              busy_d[r] = busy_q[r];
        end
    end

    // Busy vector register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          b;
        assign ra = rd_addr_i[k*AW +: AW];

        // Busy lookup for this read port.
        always_comb begin
`ifdef REGFILE_BYPASS_EN
            logic w_m;
            logic a_m;
            w_m = 1'b0;
            a_m = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_valid_i[j]    && wr_addr_i[j*AW +: AW]    == ra) w_m = 1'b1;
                if (alloc_valid_i[j] && alloc_addr_i[j*AW +: AW] == ra) a_m = 1'b1;
            end
            b = busy_q[ra];
            if (w_m && !a_m) b = 1'b0;
`else
            b = busy_q[ra];
`endif
            if (ra == '0) b = 1'b0;
        end

        assign rd_busy_o[k] = b;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported integer register file with busy-bit scoreboard.
// Optional REGFILE_BYPASS_EN forwards same-cycle writeback data to reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 6,
    parameter int NUM_WR   = 2,
    localparam int AW      = $clog2(NUM_REGS)
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_RD*AW-1:0]   rd_addr_i,
    output logic [NUM_RD*XLEN-1:0] rd_data_o,
    output logic [NUM_RD-1:0]      rd_busy_o,
    input  logic [NUM_WR-1:0]      wr_valid_i,
    input  logic [NUM_WR*AW-1:0]   wr_addr_i,
    input  logic [NUM_WR*XLEN-1:0] wr_data_i,
    input  logic [NUM_WR-1:0]      alloc_valid_i,
    input  logic [NUM_WR*AW-1:0]   alloc_addr_i,
    input  logic                   flush_i
);

    logic [NUM_REGS-1:0][XLEN-1:0] regs;

    // Commit writes; later ports overwrite earlier ones, so the youngest wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_valid_i[j] && wr_addr_i[j*AW +: AW] != '0)
                    regs[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdata;
        assign ra = rd_addr_i[k*AW +: AW];

        // Read mux, optionally overridden by the youngest matching write.
        always_comb begin
            rdata = regs[ra];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_valid_i[j] && wr_addr_i[j*AW +: AW] == ra)
                    rdata = wr_data_i[j*XLEN +: XLEN];
            end
`endif
            if (ra == '0) rdata = '0;
        end

        assign rd_data_o[k*XLEN +: XLEN] = rdata;
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .AW       (AW)
    ) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_addr_i     (rd_addr_i),
        .rd_busy_o     (rd_busy_o),
        .wr_valid_i    (wr_valid_i),
        .wr_addr_i     (wr_addr_i),
        .alloc_valid_i (alloc_valid_i),
        .alloc_addr_i  (alloc_addr_i),
        .flush_i       (flush_i)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed scenarios followed by random
// traffic, with expected read results from an array-based reference model.
module tb_regfile_mp;

    localparam int XLEN = 64;
    localparam int NR   = 32;
    localparam int NRD  = 6;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wr_valid;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;
    logic [NWR-1:0]       alloc_valid;
    logic [NWR*AW-1:0]    alloc_addr;
    logic                 flush;

    regfile_mp dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .rd_busy_o     (rd_busy),
        .wr_valid_i    (wr_valid),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .alloc_valid_i (alloc_valid),
        .alloc_addr_i  (alloc_addr),
        .flush_i       (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                  cyc;
        logic [NRD*XLEN-1:0] data;
        logic [NRD-1:0]      busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model state.
    logic [XLEN-1:0] m_mem [NR];
    bit              m_busy[NR];
    bit              m_valid = 0;

    function automatic int fa(input logic [NWR*AW-1:0] v, input int j);
        return int'(v[j*AW +: AW]);
    endfunction

    // Expected read results from current model state and current inputs.
    task automatic push_expect();
        exp_t e;
        e.cyc = cycle;
        for (int k = 0; k < NRD; k++) begin
            int a;
            logic [XLEN-1:0] d;
            bit b;
            a = int'(rd_addr[k*AW +: AW]);
            d = m_mem[a];
            b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
            begin
                bit wm, am;
                wm = 0; am = 0;
                for (int j = 0; j < NWR; j++) begin
                    if (wr_valid[j] && fa(wr_addr, j) == a) begin
                        wm = 1; d = wr_data[j*XLEN +: XLEN];
                    end
                    if (alloc_valid[j] && fa(alloc_addr, j) == a) am = 1;
                end
                if (wm && !am) b = 0;
            end
`endif
            if (a == 0) begin d = '0; b = 0; end
            e.data[k*XLEN +: XLEN] = d;
            e.busy[k] = b;
        end
        exp_q.push_back(e);
    endtask

    // Apply one clock edge to the model.
    task automatic model_edge();
        if (!rst_n) begin
            for (int r = 0; r < NR; r++) begin m_mem[r] = '0; m_busy[r] = 0; end
            m_valid = 1;
            return;
        end
        for (int r = 1; r < NR; r++) begin
            bit al, wb;
            al = 0; wb = 0;
            for (int j = 0; j < NWR; j++) begin
                if (alloc_valid[j] && fa(alloc_addr, j) == r) al = 1;
                if (wr_valid[j] && fa(wr_addr, j) == r) begin
                    wb = 1;
                    m_mem[r] = wr_data[j*XLEN +: XLEN];
                end
            end
            if (al)         m_busy[r] = 1;
            else if (flush) m_busy[r] = 0;
            else if (wb)    m_busy[r] = 0;
        end
    endtask

    task automatic step();
        if (m_valid) push_expect();
        @(posedge clk);
        model_edge();
        cycle++;
        #1;
    endtask

    task automatic idle();
        rst_n = 1; wr_valid = '0; wr_addr = '0; wr_data = '0;
        alloc_valid = '0; alloc_addr = '0; flush = 0;
        for (int k = 0; k < NRD; k++) rd_addr[k*AW +: AW] = AW'(k + 1);
    endtask

    task automatic rd_all(input int a);
        for (int k = 0; k < NRD; k++) rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic wr(input int j, input int a, input logic [XLEN-1:0] d);
        wr_valid[j] = 1; wr_addr[j*AW +: AW] = AW'(a); wr_data[j*XLEN +: XLEN] = d;
    endtask

    task automatic al(input int j, input int a);
        alloc_valid[j] = 1; alloc_addr[j*AW +: AW] = AW'(a);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (rd_data !== e.data) begin
                errors++;
                $display("FAIL rd_data cyc %0d: got %h want %h", e.cyc, rd_data, e.data);
            end
            checks++;
            if (rd_busy !== e.busy) begin
                errors++;
                $display("FAIL rd_busy cyc %0d: got %b want %b", e.cyc, rd_busy, e.busy);
            end
        end
    end

    initial begin
        idle();
        rst_n = 0;
        rd_addr = '0;
        #1;
        // Reset, then sweep every address on every port.
        step();
        idle();
        for (int a = 0; a < NR; a++) begin rd_all(a); step(); end

        // Same-address write conflict: port 1 wins.
        idle(); wr(0, 5, 64'h11); wr(1, 5, 64'h22); rd_all(5); step();
        idle(); rd_all(5); step();

        // x0 protection.
        idle(); wr(0, 0, 64'hDEAD); al(1, 0); rd_all(0); step();
        idle(); rd_all(0); step();

        // Scoreboard lifecycle on x7.
        idle(); al(0, 7); rd_all(7); step();
        idle(); rd_all(7); step();
        idle(); rd_all(7); step();
        idle(); wr(0, 7, 64'h99); rd_all(7); step();
        idle(); rd_all(7); step();

        // Allocate and writeback collide on x9.
        idle(); al(0, 9); rd_all(9); step();
        idle(); wr(0, 9, 64'h1); al(1, 9); rd_all(9); step();
        idle(); rd_all(9); step();

        // Flush with a simultaneous allocate.
        idle(); al(0, 3); al(1, 4); step();
        idle(); flush = 1; al(0, 4);
        rd_addr[0 +: AW] = 5'd3; rd_addr[AW +: AW] = 5'd4; step();
        idle(); rd_addr[0 +: AW] = 5'd3; rd_addr[AW +: AW] = 5'd4; step();

        // Random traffic over a narrow address range to force collisions.
        for (int i = 0; i < 1500; i++) begin
            idle();
            rst_n = ($urandom_range(0, 199) != 0);
            flush = ($urandom_range(0, 19) == 0);
            for (int j = 0; j < NWR; j++) begin
                if ($urandom_range(0, 1) == 1) wr(j, $urandom_range(0, 9), {$urandom, $urandom});
                if ($urandom_range(0, 2) == 0) al(j, $urandom_range(0, 9));
            end
            for (int k = 0; k < NRD; k++) rd_addr[k*AW +: AW] = AW'($urandom_range(0, 11));
            step();
        end

        // Reset mid-stream with writes pending, then sweep all addresses.
        idle(); rst_n = 0; wr(0, 3, 64'h55); al(1, 6); step();
        idle();
        for (int a = 0; a < NR; a++) begin rd_all(a); step(); end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
